fir_coeff_sequencer: RTL
========================

# fir_coeff_sequencer

Controller in front of the 41-tap FIR datapath. It loads a full coefficient set from a valid/ready stream through the FIR's `coeff_update`/`coeff_sel`/`new_coeff` write port. It then flushes the tap delay line so no output mixes old and new coefficients. Finally it gates the sample stream into the filter and qualifies the filter output with a valid strobe. It sits between the host configuration path / sample source and the free-running FIR instance.

## Interface

- `NTAPS`, 41: number of taps and coefficients per load.
- `DW`, 16: sample and coefficient width.
- `AW`, 6: coefficient index width; must satisfy 2**AW >= NTAPS.
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a coefficient load.
- `abort` input 1: cancels an in-progress load or flush.
- `cfg_valid` input 1: coefficient word valid.
- `cfg_ready` output 1: block accepts a coefficient word.
- `cfg_data` input DW: coefficient word; index order is 0 to NTAPS-1.
- `coeff_update` output 1: FIR coefficient write strobe.
- `coeff_sel` output AW: FIR coefficient index.
- `new_coeff` output DW: FIR coefficient value.
- `smp_valid` input 1: input sample valid.
- `smp_data` input DW: input sample.
- `fir_din` output DW: sample to FIR `din`.
- `fir_dout` input 2*DW: FIR `dout`.
- `out_valid` output 1: `out_data` holds a valid filtered sample.
- `out_data` output 2*DW: filtered sample; combinational pass-through of `fir_dout`.
- `busy` output 1: high in LOAD or FLUSH.
- `done` output 1: one-cycle pulse on entry to RUN.
- `err` output 1: one-cycle pulse when an abort is taken.
- `drop` output 1: high in any cycle where `smp_valid`=1 outside RUN.

## Operation

- The FSM has four states: IDLE, LOAD, FLUSH and RUN.
- Reset behaviour:
  - State goes to IDLE.
  - The index counter and flush counter clear to 0.
  - Registered outputs go to 0: `coeff_update`, `coeff_sel`, `new_coeff`, `out_valid`, `done`, `err`.
  - Combinational outputs in IDLE are also 0: `cfg_ready`, `busy`, `fir_din`.
- IDLE:
  - Coefficients are undefined, and no output is ever qualified valid.
  - `start` moves to LOAD with idx=0.
- LOAD:
  - `cfg_ready`=1.
  - Each handshake (`cfg_valid`&`cfg_ready`) registers `coeff_sel`<=idx, `new_coeff`<=`cfg_data` and `coeff_update`<=1 for exactly one cycle, then increments idx.
  - The handshake with idx==NTAPS-1 moves to FLUSH with fcnt=0.
  - A stalled `cfg_valid` holds the state indefinitely; there is no timeout.
- FLUSH:
  - `cfg_ready`=0.
  - fcnt increments every cycle.
  - When fcnt==NTAPS-1, the FSM moves to RUN and pulses `done`.
- RUN:
  - `fir_din` = `smp_valid` ? `smp_data` : 0, combinationally.
  - `out_valid`<=`smp_valid` (registered).
  - `start` moves to LOAD (reload), and `out_valid` goes to 0 from the next cycle.
- Outside RUN:
  - `fir_din`=0.
  - Input samples are discarded, with `drop` asserted.
- The FIR shifts every clock. A cycle in RUN with `smp_valid`=0 therefore inserts a zero sample. That is the defined behaviour, and `out_valid`=0 for that cycle's output.
- Abort:
  - `abort` in LOAD or FLUSH moves to IDLE and pulses `err`.
  - Partially written coefficients stay in the FIR, but IDLE never qualifies outputs.
  - `abort` in IDLE or RUN is ignored.
- Simultaneous events:
  - `abort` takes priority over `start` and over the final LOAD handshake.
  - `start` in LOAD or FLUSH is ignored.
- `coeff_sel` is never driven above NTAPS-1.

## Timing

- Coefficient write latency: a handshake at cycle t produces `coeff_update` at t+1.
- The final coefficient is written at cycle T+1, where T is the last handshake cycle, which is also the first FLUSH cycle.
- FLUSH lasts exactly NTAPS cycles, during which zeros are shifted through the delay line.
- `done` is high in the first RUN cycle, T+1+NTAPS.
- Sample latency: `smp_data` presented in RUN cycle t appears in `fir_dout`/`out_data` at t+1, qualified by `out_valid`=1 at t+1.
- A full load with back-to-back `cfg_valid` takes NTAPS cycles of LOAD plus NTAPS cycles of FLUSH.
- `busy` is combinational from state.

## Structure

- The shared package `fir_ctrl_pkg` holds:
  - constants NTAPS=41, DW=16, AW=6;
  - the state enum type `fir_seq_state_t` (IDLE, LOAD, FLUSH, RUN);
  - typedefs `sample_t` (DW) and `acc_t` (2*DW).
- One natural sub-module is `tap_counter`: a parameterised up-counter with clear, enable and a terminal-count flag. It is instantiated twice, once for idx and once for fcnt.
- The FIR itself is instantiated by the parent, not by this block.

## Test plan

- **Reset:** assert `reset`=0 mid-LOAD at idx=17.
  - Immediately (asynchronously): all outputs are 0 and state is IDLE.
  - After release, `start` restarts at `coeff_sel`=0.
- **Full load:** 41 back-to-back words with value 1000+i.
  - Expect 41 `coeff_update` strobes, with `coeff_sel`=0..40 in order and `new_coeff`=1000+i.
  - Expect `done` exactly 41 cycles after the last strobe.
  - Expect `busy` to fall in the same cycle `done` rises.
- **Impulse:** coefficients h[i]=i+1; in RUN, send one sample of 1 followed by zeros.
  - `out_data` must be 1, 2, …, 41, then 0, with `out_valid` high.
  - The first output appears one cycle after the impulse.
- **Stalled config:** toggle `cfg_valid` randomly (50%) and drive `smp_valid`=1 throughout.
  - Coefficient writes stay ordered.
  - `drop`=1 on every non-RUN cycle.
  - `out_valid` is never 1 before `done`.
- **Abort priority:** assert `abort` and `start` together with the 41st handshake.
  - `err` pulses, state goes to IDLE, and `done` never fires.
  - `start` in LOAD, by contrast, leaves idx unchanged.
- **Reload from RUN:** `start` while streaming.
  - `out_valid` goes to 0 from the next cycle.
  - After the new load and flush, the impulse response matches the new coefficients, with no mixed-coefficient output.

Source files
------------

// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_ctrl_pkg
// Description : Shared constants and types for the FIR coefficient sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_ctrl_pkg;

    localparam int NTAPS = 41;
    localparam int DW    = 16;
    localparam int AW    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } fir_seq_state_t;

    typedef logic [DW-1:0]   sample_t;
    typedef logic [2*DW-1:0] acc_t;

endpackage
`default_nettype wire

// File: rtl/tap_counter.sv
`default_nettype none
// ============================================================================
// Module      : tap_counter
// Description : Up-counter with synchronous clear, enable and a flag that is
//               high while the count equals TERMINAL.
// Revision    : 1.0 - initial release
// ============================================================================
module tap_counter #(
    parameter int W        = 6,
    parameter int TERMINAL = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;

    // Clear wins over enable so the owner can hold the count at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == W'(TERMINAL));

endmodule
`default_nettype wire

// File: rtl/fir_coeff_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_sequencer
// Description : Loads a coefficient set into the FIR, flushes its delay line
//               with zeros, then gates samples in and qualifies outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_sequencer #(
    parameter int NTAPS = fir_ctrl_pkg::NTAPS,
    parameter int DW    = fir_ctrl_pkg::DW,
    parameter int AW    = fir_ctrl_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic [DW-1:0]   cfg_data_i,
    output logic            coeff_update_o,
    output logic [AW-1:0]   coeff_sel_o,
    output logic [DW-1:0]   new_coeff_o,
    input  logic            smp_valid_i,
    input  logic [DW-1:0]   smp_data_i,
    output logic [DW-1:0]   fir_din_o,
    input  logic [2*DW-1:0] fir_dout_i,
    output logic            out_valid_o,
    output logic [2*DW-1:0] out_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            drop_o
);

    import fir_ctrl_pkg::*;

    fir_seq_state_t state_q;

    logic            coeff_update_q;
    logic [AW-1:0]   coeff_sel_q;
    logic [DW-1:0]   new_coeff_q;
    logic            out_valid_q;
    logic            done_q;
    logic            err_q;

    logic [AW-1:0]   idx;
    logic            idx_tc;
    logic [AW-1:0]   fcnt_unused;
    logic            fcnt_tc;
    logic            hs;

    // A coefficient word is consumed whenever LOAD sees cfg_valid.
    assign hs = (state_q == LOAD) && cfg_valid_i;

    // Coefficient index: parked at zero outside LOAD, steps on each accepted word.
    tap_counter #(
        .W        (AW),
        .TERMINAL (NTAPS - 1)
    ) u_idx_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q != LOAD),
        .en_i    (hs && !abort_i),
        .count_o (idx),
        .tc_o    (idx_tc)
    );

    // Flush length counter: parked at zero outside FLUSH, steps every FLUSH cycle.
    tap_counter #(
        .W        (AW),
        .TERMINAL (NTAPS - 1)
    ) u_fcnt_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (state_q != FLUSH),
        .en_i    (state_q == FLUSH),
        .count_o (fcnt_unused),
        .tc_o    (fcnt_tc)
    );

    // Sequencer FSM with registered strobes; abort outranks start and the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            coeff_update_q <= 1'b0;
            coeff_sel_q    <= '0;
            new_coeff_q    <= '0;
            out_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            coeff_update_q <= 1'b0;
            out_valid_q    <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (cfg_valid_i) begin
                        coeff_update_q <= 1'b1;
                        coeff_sel_q    <= idx;
                        new_coeff_q    <= cfg_data_i;
                        if (idx_tc) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (fcnt_tc) begin
                        state_q <= RUN;
                        done_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_i) begin
                        state_q <= LOAD;
                    end else begin
                        out_valid_q <= smp_valid_i;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o    = (state_q == LOAD);
    assign busy_o         = (state_q == LOAD) || (state_q == FLUSH);
    assign fir_din_o      = ((state_q == RUN) && smp_valid_i) ? smp_data_i : '0;
    assign drop_o         = smp_valid_i && (state_q != RUN);
    assign out_data_o     = fir_dout_i;

    assign coeff_update_o = coeff_update_q;
    assign coeff_sel_o    = coeff_sel_q;
    assign new_coeff_o    = new_coeff_q;
    assign out_valid_o    = out_valid_q;
    assign done_o         = done_q;
    assign err_o          = err_q;

endmodule
`default_nettype wire
